dff_shared_reg_arb: RTL and testbench

//  Round-robin write arbiter for one shared register built from DFFs. Two

---
 rtl/dff_pkg.sv | 15 +
 rtl/dff_en_rst.sv | 28 ++
 rtl/dff_shared_reg_arb.sv | 154 +++++++++++++++
 tb/tb_dff_shared_reg_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared types and requester ids for the shared-register arbiter.
package dff_pkg;

  // Requester identifier: one bit, two competing producers.
  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Id of the requester that is not 'id'; becomes the favoured one after 'id' wins.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage : dff_pkg

// File: rtl/dff_en_rst.sv
// D flip-flop bank with synchronous active-high reset and load enable.
module dff_en_rst #(
  parameter int unsigned         p_nbits       = 8,
  parameter logic [p_nbits-1:0]  p_reset_value = {p_nbits{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  logic [p_nbits-1:0] q_r;

  // Reset has priority over the enable; without enable the value holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= p_reset_value;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule : dff_en_rst

// File: rtl/dff_shared_reg_arb.sv
// Round-robin write arbiter in front of one shared DFF register.
// Two val/rdy requesters compete; the granted message is captured on the
// next rising edge together with a valid flag and the writer's id.
module dff_shared_reg_arb
  import dff_pkg::*;
#(
  parameter int unsigned        p_nbits       = 8,
  parameter logic [p_nbits-1:0] p_reset_value = {p_nbits{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic [p_nbits-1:0] req0_msg,
  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic [p_nbits-1:0] req1_msg,
  input  logic               clr,
  output logic [p_nbits-1:0] q,
  output logic               q_val,
  output logic               q_src
);

  // Current state, as seen at the DFF outputs.
  logic [p_nbits-1:0] q_r;
  logic               q_val_r;
  req_id_t            q_src_r;
  req_id_t            prio_r;

  // Grant and next-state signals.
  logic               grant0_s;
  logic               grant1_s;
  logic               fire_s;
  logic [p_nbits-1:0] q_d_s;
  logic               q_en_s;
  logic               q_val_d_s;
  logic               q_val_en_s;
  req_id_t            q_src_d_s;
  req_id_t            prio_d_s;

  // Grant arbitration plus next-state/enable generation for every DFF.
  always_comb begin
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    fire_s     = 1'b0;
    q_d_s      = q_r;
    q_en_s     = 1'b0;
    q_val_d_s  = q_val_r;
    q_val_en_s = 1'b0;
    q_src_d_s  = q_src_r;
    prio_d_s   = prio_r;

    // No grant while reset is asserted; the reset edge drops it anyway.
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_val && req1_val) begin
      if (prio_r == REQ0) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_val) begin
      grant0_s = 1'b1;
    end else if (req1_val) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end

    // A grant is a fire because val is already qualified above.
    fire_s = grant0_s | grant1_s;

    if (grant1_s) begin
      q_d_s     = req1_msg;
      q_src_d_s = REQ1;
      prio_d_s  = other_req(REQ1);
    end else if (grant0_s) begin
      q_d_s     = req0_msg;
      q_src_d_s = REQ0;
      prio_d_s  = other_req(REQ0);
    end else begin
      q_d_s     = q_r;
      q_src_d_s = q_src_r;
      prio_d_s  = prio_r;
    end

    q_en_s = fire_s;

    // A write always leaves the register valid, even if clr is also high.
    if (fire_s) begin
      q_val_d_s  = 1'b1;
      q_val_en_s = 1'b1;
    end else if (clr) begin
      q_val_d_s  = 1'b0;
      q_val_en_s = 1'b1;
    end else begin
      q_val_d_s  = q_val_r;
      q_val_en_s = 1'b0;
    end
  end

  dff_en_rst #(
    .p_nbits       (p_nbits),
    .p_reset_value (p_reset_value)
  ) u_q_reg (
    .clk   (clk),
    .reset (reset),
    .en    (q_en_s),
    .d     (q_d_s),
    .q     (q_r)
  );

  dff_en_rst #(
    .p_nbits       (1),
    .p_reset_value (1'b0)
  ) u_q_val_reg (
    .clk   (clk),
    .reset (reset),
    .en    (q_val_en_s),
    .d     (q_val_d_s),
    .q     (q_val_r)
  );

  dff_en_rst #(
    .p_nbits       (1),
    .p_reset_value (REQ0)
  ) u_q_src_reg (
    .clk   (clk),
    .reset (reset),
    .en    (q_en_s),
    .d     (q_src_d_s),
    .q     (q_src_r)
  );

  dff_en_rst #(
    .p_nbits       (1),
    .p_reset_value (REQ0)
  ) u_prio_reg (
    .clk   (clk),
    .reset (reset),
    .en    (q_en_s),
    .d     (prio_d_s),
    .q     (prio_r)
  );

  assign req0_rdy = grant0_s;
  assign req1_rdy = grant1_s;
  assign q        = q_r;
  assign q_val    = q_val_r;
  assign q_src    = q_src_r;

endmodule : dff_shared_reg_arb

// File: tb/tb_dff_shared_reg_arb.sv
// Self-checking bench: directed vector table, a starvation sequence and
// randomized traffic compared against a behavioural model.
module tb_dff_shared_reg_arb;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_val, req1_val, clr;
  logic [NB-1:0] req0_msg, req1_msg;
  logic          req0_rdy, req1_rdy;
  logic [NB-1:0] q;
  logic          q_val, q_src;

  int total = 0;
  int bad   = 0;

  dff_shared_reg_arb #(.p_nbits(NB), .p_reset_value(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0_val (req0_val),
    .req0_rdy (req0_rdy),
    .req0_msg (req0_msg),
    .req1_val (req1_val),
    .req1_rdy (req1_rdy),
    .req1_msg (req1_msg),
    .clr      (clr),
    .q        (q),
    .q_val    (q_val),
    .q_src    (q_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          v0;
    logic [NB-1:0] m0;
    logic          v1;
    logic [NB-1:0] m1;
    logic          clr;
    logic          r0;
    logic          r1;
    logic [NB-1:0] eq;
    logic          eqv;
    logic          eqs;
  } vec_t;

  // Behavioural model: register contents plus "who gets the next tie".
  int m_q;
  int m_val;
  int m_src;
  int m_fav;

  function automatic vec_t mk(input logic rst, input logic v0, input logic [NB-1:0] m0,
                              input logic v1, input logic [NB-1:0] m1, input logic c,
                              input logic r0, input logic r1, input logic [NB-1:0] eq,
                              input logic eqv, input logic eqs);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.m0 = m0; v.v1 = v1; v.m1 = m1; v.clr = c;
    v.r0 = r0; v.r1 = r1; v.eq = eq; v.eqv = eqv; v.eqs = eqs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model winner: -1 none; a lone requester wins; a tie goes to the favoured one.
  function automatic int model_winner(input vec_t v);
    if (v.rst) return -1;
    if (v.v0 && v.v1) return m_fav;
    if (v.v0) return 0;
    if (v.v1) return 1;
    return -1;
  endfunction

  // Apply one cycle of inputs; compare against the table row or the model.
  task automatic apply(input vec_t v, input bit use_tbl, input string tag);
    int w;
    logic er0, er1;
    reset = v.rst; req0_val = v.v0; req0_msg = v.m0;
    req1_val = v.v1; req1_msg = v.m1; clr = v.clr;
    #1;
    w = model_winner(v);
    er0 = use_tbl ? v.r0 : (w == 0);
    er1 = use_tbl ? v.r1 : (w == 1);
    check({tag, ".rdy0"}, {31'd0, req0_rdy}, {31'd0, er0});
    check({tag, ".rdy1"}, {31'd0, req1_rdy}, {31'd0, er1});
    @(posedge clk);
    if (v.rst) begin
      m_q = 0; m_val = 0; m_src = 0; m_fav = 0;
    end else if (w >= 0) begin
      m_q = (w == 0) ? int'(v.m0) : int'(v.m1);
      m_val = 1; m_src = w; m_fav = 1 - w;
    end else if (v.clr) begin
      m_val = 0;
    end
    #1;
    if (use_tbl) begin
      check({tag, ".q"},     {24'd0, q},     {24'd0, v.eq});
      check({tag, ".q_val"}, {31'd0, q_val}, {31'd0, v.eqv});
      check({tag, ".q_src"}, {31'd0, q_src}, {31'd0, v.eqs});
    end else begin
      check({tag, ".q"},     {24'd0, q},     m_q);
      check({tag, ".q_val"}, {31'd0, q_val}, m_val);
      check({tag, ".q_src"}, {31'd0, q_src}, m_src);
    end
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t v;
  int   lose0, lose1;

  initial begin
    m_q = 0; m_val = 0; m_src = 0; m_fav = 0;
    reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0; clr = 1'b0;
    req0_msg = 8'h00; req1_msg = 8'h00;

    //            rst   v0    m0     v1    m1     clr   r0    r1    q      qv    qs
    // reset
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    // single requester 0
    tbl.push_back(mk(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0));
    // prio is now 1: a tie goes to req1
    tbl.push_back(mk(1'b0, 1'b1, 8'h66, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1));
    // reset, then contention alternates 0,1,0,1
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1));
    // clr vs fire
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0));
    // reset with both val and clr: no write, then req0 wins the first tie
    tbl.push_back(mk(1'b1, 1'b1, 8'h55, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h55, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0));
    // idle with changing messages: state holds
    tbl.push_back(mk(1'b0, 1'b0, 8'hA1, 1'b0, 8'hB1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'hA2, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'hA3, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'hA4, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'hA5, 1'b0, 8'hB5, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0));
    // prio survived idling: the tie goes to req1
    tbl.push_back(mk(1'b0, 1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Sustained contention: neither side loses two cycles in a row.
    lose0 = 0; lose1 = 0;
    for (int i = 0; i < 8; i++) begin
      v = mk(1'b0, 1'b1, 8'(i), 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0; req0_val = 1'b1; req1_val = 1'b1;
      #1;
      lose0 = req0_rdy ? 0 : lose0 + 1;
      lose1 = req1_rdy ? 0 : lose1 + 1;
      check("starve0", (lose0 <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("starve1", (lose1 <= 1) ? 32'd1 : 32'd0, 32'd1);
      apply(v, 1'b0, $sformatf("cont%0d", i));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
             1'($urandom_range(1)), 8'($urandom),
             1'($urandom_range(1)), 8'($urandom),
             ($urandom_range(3) == 0) ? 1'b1 : 1'b0,
             1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      apply(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dff_shared_reg_arb
